// File: rtl/pwm_pkg.sv
// Shared constants and the per-pin drive rule for the PWM output stage.
package pwm_pkg;

  localparam int PWM_BITS        = 8;
  localparam int NUM_PINS        = 16;
  localparam int DEFAULT_CLK_DIV = 13;

  localparam logic [PWM_BITS-1:0] DUTY_FULL = 8'hFF;
  localparam logic [PWM_BITS-1:0] CNT_MAX   = 8'hFF;

  // A disabled pin is always low; PWM select only matters once the pin is enabled.
  function automatic logic pin_drive(input logic en_out, input logic en_pwm, input logic level);
    logic drive;
    if (!en_out) begin
      drive = 1'b0;
    end else if (!en_pwm) begin
      drive = 1'b1;
    end else begin
      drive = level;
    end
    return drive;
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, 8-bit period counter and the duty shadow
// register that only updates at the period boundary.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] duty_i,
  output logic                pwm_level_o,
  output logic                wrap_o
);

  localparam logic [7:0] PRESCALE_MAX = 8'(CLK_DIV - 1);

  logic [7:0]          prescaler_q, prescaler_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                tick;

  assign tick   = (prescaler_q == PRESCALE_MAX);
  assign wrap_o = tick && (cnt_q == CNT_MAX);

  always_comb begin
    prescaler_d = prescaler_q;
    cnt_d       = cnt_q;
    duty_d      = duty_q;
    if (tick) begin
      prescaler_d = 8'd0;
      cnt_d       = cnt_q + 8'd1;
    end else begin
      prescaler_d = prescaler_q + 8'd1;
      cnt_d       = cnt_q;
    end
    // Duty is double-buffered so a mid-period write never produces a runt pulse.
    if (wrap_o) begin
      duty_d = duty_i;
    end else begin
      duty_d = duty_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler_q <= 8'd0;
      cnt_q       <= 8'd0;
      duty_q      <= 8'd0;
    end else begin
      prescaler_q <= prescaler_d;
      cnt_q       <= cnt_d;
      duty_q      <= duty_d;
    end
  end

  // Full-scale duty stays high through the boundary instead of dropping for one step.
  always_comb begin
    pwm_level_o = 1'b0;
    if (duty_q == DUTY_FULL) begin
      pwm_level_o = 1'b1;
    end else begin
      pwm_level_o = (cnt_q < duty_q);
    end
  end

endmodule

// File: rtl/pwm_peripheral.sv
// 16-pin output stage: each pin is off, on, or follows the shared PWM level.
// Pin drive and the period marker are registered.
module pwm_peripheral
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          en_reg_out_7_0,
  input  logic [7:0]          en_reg_out_15_8,
  input  logic [7:0]          en_reg_pwm_7_0,
  input  logic [7:0]          en_reg_pwm_15_8,
  input  logic [PWM_BITS-1:0] pwm_duty_cycle,
  output logic [NUM_PINS-1:0] out,
  output logic                period_start
);

  logic [NUM_PINS-1:0] en_out, en_pwm;
  logic [NUM_PINS-1:0] out_q, out_d;
  logic                period_start_q, period_start_d;
  logic                pwm_level;
  logic                wrap;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  pwm_timebase #(
    .CLK_DIV(CLK_DIV)
  ) u_timebase (
    .clk        (clk),
    .rst        (rst),
    .duty_i     (pwm_duty_cycle),
    .pwm_level_o(pwm_level),
    .wrap_o     (wrap)
  );

  always_comb begin
    out_d = '0;
    for (int i = 0; i < NUM_PINS; i++) begin
      out_d[i] = pin_drive(en_out[i], en_pwm[i], pwm_level);
    end
    period_start_d = wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q          <= 16'h0000;
      period_start_q <= 1'b0;
    end else begin
      out_q          <= out_d;
      period_start_q <= period_start_d;
    end
  end

  assign out          = out_q;
  assign period_start = period_start_q;

endmodule

// File: tb/tb_pwm_peripheral.sv
// Directed bench for pwm_peripheral with a cycle-count based reference model.
module tb_pwm_peripheral;

  localparam int D   = 13;
  localparam int PER = D * 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  eo_lo, eo_hi, ep_lo, ep_hi, duty;
  logic [15:0] out;
  logic        period_start;

  int n_vec  = 0;
  int n_miss = 0;
  bit chk_on = 1'b0;

  // Model state: edges since reset release, latched duty, expected outputs.
  int          k;
  int          duty_m;
  logic [15:0] exp_out;
  logic        exp_ps;

  always #5 clk = ~clk;

  pwm_peripheral #(.CLK_DIV(D)) dut (
    .clk            (clk),
    .rst            (rst),
    .en_reg_out_7_0 (eo_lo),
    .en_reg_out_15_8(eo_hi),
    .en_reg_pwm_7_0 (ep_lo),
    .en_reg_pwm_15_8(ep_hi),
    .pwm_duty_cycle (duty),
    .out            (out),
    .period_start   (period_start)
  );

  // Pin value implied by being 'kk' clocks into time since release.
  function automatic logic [15:0] model_out(input int kk, input int dm,
                                            input logic [15:0] eo, input logic [15:0] ep);
    int          step;
    logic        lvl;
    logic [15:0] r;
    step = (kk / D) % 256;
    lvl  = (dm == 255) || (step < dm);
    r    = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      if (eo[i]) r[i] = ep[i] ? lvl : 1'b1;
    end
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k       <= 0;
      duty_m  <= 0;
      exp_out <= 16'h0000;
      exp_ps  <= 1'b0;
    end else begin
      exp_out <= model_out(k, duty_m, {eo_hi, eo_lo}, {ep_hi, ep_lo});
      exp_ps  <= ((k % PER) == PER - 1);
      if ((k % PER) == PER - 1) duty_m <= int'(duty);
      k <= k + 1;
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    n_vec++;
    if (act != expv) begin
      n_miss++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at t=%0t", name, act, act, expv, expv, $time);
    end
  endtask

  task automatic wait_ps(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (period_start !== 1'b1 && n < 2 * PER);
    if (period_start !== 1'b1) chk("period_start_timeout", 0, 1);
  endtask

  // Count high samples of one pin over the period following a period_start sample.
  task automatic measure(input int b, input int mid_j, input logic [7:0] mid_duty, output int hi);
    hi = 0;
    for (int j = 1; j <= PER; j++) begin
      @(negedge clk);
      if (out[b] === 1'b1) hi++;
      if (j == mid_j) duty = mid_duty;
    end
  endtask

  logic [7:0] duty_tab [3];
  int         hi_tab   [3];
  int         n, hi;

  initial begin
    duty_tab = '{8'h00, 8'hFF, 8'h01};
    hi_tab   = '{0, PER, 13};
    rst = 1'b1;
    eo_lo = 8'hFF; eo_hi = 8'hFF; ep_lo = 8'hFF; ep_hi = 8'hFF; duty = 8'hFF;

    fork
      begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
      end
      forever begin
        @(negedge clk);
        if (chk_on && !rst) begin
          chk("out_cycle", int'(out), int'(exp_out));
          chk("period_start_cycle", int'(period_start), int'(exp_ps));
        end
      end
    join_none

    // 1: reset state, first period latency and first loaded duty
    repeat (3) @(negedge clk);
    chk("reset_out", int'(out), 32'h0);
    chk("reset_ps", int'(period_start), 0);
    chk_on = 1'b1;
    rst = 1'b0;
    wait_ps(n);
    chk("first_ps_latency", n, 3328);
    measure(0, 0, 8'h00, hi);
    chk("duty_ff_after_first_wrap", hi, 3328);

    // 2: static drive of a single pin
    eo_lo = 8'h01; eo_hi = 8'h00; ep_lo = 8'h00; ep_hi = 8'h00;
    repeat (2) @(negedge clk);
    chk("static_pin0", int'(out), 32'h0001);
    repeat (3 * PER) @(negedge clk);

    // 3: half duty on pin 1, pin 0 static on
    eo_lo = 8'h03; ep_lo = 8'h02; duty = 8'h80;
    wait_ps(n);
    measure(1, 0, 8'h00, hi);
    chk("duty80_high_p1", hi, 1664);
    measure(1, 0, 8'h00, hi);
    chk("duty80_high_p2", hi, 1664);

    // 4: duty sweep on all pins
    eo_lo = 8'hFF; eo_hi = 8'hFF; ep_lo = 8'hFF; ep_hi = 8'hFF;
    for (int t = 0; t < 3; t++) begin
      duty = duty_tab[t];
      wait_ps(n);
      measure(15, 0, 8'h00, hi);
      chk("sweep_high", hi, hi_tab[t]);
      if (t == 1) begin
        measure(7, 0, 8'h00, hi);
        chk("sweep_ff_second_period", hi, PER);
      end
    end

    // 5: mid-period duty write takes effect only at the next boundary
    duty = 8'h40;
    wait_ps(n);
    measure(3, 1600, 8'hC0, hi);
    chk("shadow_old_duty", hi, 832);
    measure(3, 0, 8'h00, hi);
    chk("shadow_new_duty", hi, 2496);

    // 6: asynchronous reset mid-period
    duty = 8'h80;
    wait_ps(n);
    wait_ps(n);
    repeat (1305) @(negedge clk);
    chk("pre_reset_out", int'(out), 32'hFFFF);
    #1 rst = 1'b1;
    #1;
    chk("async_reset_out", int'(out), 32'h0);
    chk("async_reset_ps", int'(period_start), 0);
    @(negedge clk);
    rst = 1'b0;
    wait_ps(n);
    chk("ps_latency_after_reset", n, 3328);
    measure(0, 0, 8'h00, hi);
    chk("duty80_after_reset", hi, 1664);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
